// File: rtl/cpu_job_pkg.sv
// Shared types and default constants for the CPU job loader.
package cpu_job_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } job_state_t;

  localparam logic [2:0]  FUNCT3_SW     = 3'b010;
  localparam logic [31:0] ARG_BASE_DEF  = 32'h0200_0000;
  localparam logic [31:0] RES_BASE_DEF  = 32'h0200_0010;
  localparam logic [31:0] DONE_ADDR_DEF = 32'h0200_0040;

endpackage

// File: rtl/job_result_buf.sv
// Result register file: one write port, one combinational read port,
// a written-bit per slot and a count of distinct slots written.
module job_result_buf #(
  parameter int DEPTH  = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [4:0]        widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [5:0]        count
);

  logic [DATA_W-1:0] slots [DEPTH];
  logic [DEPTH-1:0]  written;
  logic              fresh;

  // First write to a slot is what advances the count.
  always_comb begin
    fresh = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fresh = fresh | ((widx == 5'(i)) & ~written[i]);
    end
  end

  // Slot storage, written bits and count, cleared on reset or new job.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      written <= '0;
      count   <= 6'd0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (widx == 5'(i)) begin
          slots[i]   <= wdata;
          written[i] <= 1'b1;
        end
      end
      if (fresh) begin
        count <= count + 6'd1;
      end
    end else begin
      count <= count;
    end
  end

  // Indices at or beyond DEPTH match no slot and read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_data = rd_data | ({DATA_W{rd_idx == 5'(i)}} & slots[i]);
    end
  end

endmodule

// File: rtl/cpu_job_loader.sv
// Loads job arguments into data memory, runs the CPU and captures its results.
// Optional watchdog enabled by defining CPU_JOB_LOADER_TIMEOUT_EN.
module cpu_job_loader
  import cpu_job_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_ARGS    = 2,
  parameter logic [ADDR_W-1:0] ARG_BASE    = ADDR_W'(ARG_BASE_DEF),
  parameter logic [ADDR_W-1:0] RES_BASE    = ADDR_W'(RES_BASE_DEF),
  parameter int                RES_DEPTH   = 9,
  parameter logic [ADDR_W-1:0] DONE_ADDR   = ADDR_W'(DONE_ADDR_DEF),
  parameter int                TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_ARGS*DATA_W-1:0] args,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic [2:0]                 cpu_funct3,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [2:0]                 mem_funct3,
  output logic                       cpu_rst,
  output logic                       busy,
  output logic                       done,
  output logic [5:0]                 res_count,
  input  logic [4:0]                 rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       timed_out
);

  localparam logic [4:0]        LAST_ARG = 5'(NUM_ARGS - 1);
  localparam logic [ADDR_W-1:0] RES_SPAN = ADDR_W'(4 * RES_DEPTH);

  job_state_t                state;
  logic [NUM_ARGS*DATA_W-1:0] arg_lat;
  logic [4:0]                 arg_k;
  logic                       in_run;
  logic                       job_start;
  logic [ADDR_W-1:0]          res_off;
  logic                       res_hit;
  logic                       done_hit;
  logic                       timeout_hit;

  assign in_run    = (state == ST_RUN);
  assign job_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign res_off   = cpu_addr - RES_BASE;
  assign res_hit   = in_run && cpu_we && (res_off[1:0] == 2'b00) && (res_off < RES_SPAN);
  assign done_hit  = in_run && cpu_we && (cpu_addr == DONE_ADDR) && (cpu_wdata != '0);

`ifdef CPU_JOB_LOADER_TIMEOUT_EN
  logic [31:0] run_cnt;
  logic        timed_out_r;
  assign timeout_hit = in_run && (run_cnt == 32'(TIMEOUT_CYC - 1));
  assign timed_out   = timed_out_r;

  // Watchdog: counts RUN cycles from zero and flags a watchdog exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt     <= 32'd0;
      timed_out_r <= 1'b0;
    end else if (job_start) begin
      run_cnt     <= 32'd0;
      timed_out_r <= 1'b0;
    end else if (state == ST_LOAD) begin
      run_cnt     <= 32'd0;
    end else if (in_run) begin
      run_cnt     <= run_cnt + 32'd1;
      timed_out_r <= timeout_hit && !done_hit;
    end else begin
      run_cnt     <= run_cnt;
    end
  end
`else
  wire unused_timeout_cfg = ^(32'(TIMEOUT_CYC));
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  // Job sequencing and the registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cpu_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      arg_k   <= 5'd0;
      arg_lat <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          cpu_rst <= 1'b1;
          if (start) begin
            arg_lat <= args;
            arg_k   <= 5'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (arg_k == LAST_ARG) begin
            arg_k   <= 5'd0;
            cpu_rst <= 1'b0;
            state   <= ST_RUN;
          end else begin
            arg_k   <= arg_k + 5'd1;
          end
        end
        ST_RUN: begin
          if (done_hit || timeout_hit) begin
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          cpu_rst <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Data-memory write mux: argument writes in LOAD, CPU pass-through otherwise.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    case (state)
      ST_LOAD: begin
        mem_we     = 1'b1;
        mem_addr   = ARG_BASE + ADDR_W'({arg_k, 2'b00});
        mem_wdata  = arg_lat[arg_k*DATA_W +: DATA_W];
        mem_funct3 = FUNCT3_SW;
      end
      ST_RUN: begin
        mem_we = cpu_we;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  job_result_buf #(
    .DEPTH  (RES_DEPTH),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (job_start),
    .we      (res_hit),
    .widx    (res_off[6:2]),
    .wdata   (cpu_wdata),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .count   (res_count)
  );

endmodule

// File: tb/tb_cpu_job_loader.sv
// Directed bench for cpu_job_loader: load, capture table, reset abort, restart, watchdog/hang.
module tb_cpu_job_loader;

  logic        clk = 1'b0;
  logic        reset, start, cpu_we;
  logic [63:0] args;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        mem_we, cpu_rst, busy, done, timed_out;
  logic [31:0] mem_addr, mem_wdata, rd_data;
  logic [2:0]  mem_funct3;
  logic [5:0]  res_count;
  logic [4:0]  rd_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_job_loader #(.TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .start(start), .args(args),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .res_count(res_count),
    .rd_idx(rd_idx), .rd_data(rd_data), .timed_out(timed_out)
  );

  typedef struct {
    logic        st;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  idx;
    logic [31:0] exp_rd;
    logic [5:0]  exp_cnt;
    logic        exp_done;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_load(input logic [31:0] a0, input logic [31:0] a1);
    chk("load0_we", 64'(mem_we), 64'd1);
    chk("load0_addr", 64'(mem_addr), 64'h0200_0000);
    chk("load0_data", 64'(mem_wdata), 64'(a0));
    chk("load0_f3", 64'(mem_funct3), 64'd2);
    chk("load0_cpurst", 64'(cpu_rst), 64'd1);
    tick();
    chk("load1_we", 64'(mem_we), 64'd1);
    chk("load1_addr", 64'(mem_addr), 64'h0200_0004);
    chk("load1_data", 64'(mem_wdata), 64'(a1));
    chk("load1_cpurst", 64'(cpu_rst), 64'd1);
    tick();
    chk("run_cpurst", 64'(cpu_rst), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
  endtask

  initial begin
    //         st    we    addr           wdata  idx   exp_rd  cnt  done
    vecs[0] = '{1'b0, 1'b1, 32'h0200_0018, 32'hA,  5'd2, 32'hA,  6'd1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0200_0018, 32'hB,  5'd2, 32'hB,  6'd1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0200_0034, 32'h55, 5'd8, 32'h0,  6'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0200_0032, 32'h77, 5'd8, 32'h0,  6'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0200_0030, 32'h33, 5'd8, 32'h33, 6'd2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0200_0010, 32'h99, 5'd0, 32'h0,  6'd2, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0200_0040, 32'h0,  5'd0, 32'h0,  6'd2, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h0200_001C, 32'h7,  5'd3, 32'h7,  6'd3, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 32'h0200_0010, 32'hC,  5'd0, 32'hC,  6'd4, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 32'h0200_0040, 32'h1,  5'd2, 32'hB,  6'd4, 1'b1};

    reset = 1'b1; start = 1'b0; args = 64'd0; cpu_we = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_funct3 = 3'b010; rd_idx = 5'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_cpurst", 64'(cpu_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(res_count), 64'd0);
    chk("rst_timeout", 64'(timed_out), 64'd0);
    chk("rst_memwe", 64'(mem_we), 64'd0);

    // First job: SP=3, EP=17.
    args = {32'd17, 32'd3};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    check_load(32'd3, 32'd17);

    // Table of CPU stores while running.
    for (int i = 0; i < 10; i++) begin
      start = vecs[i].st; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
      cpu_wdata = vecs[i].wdata; rd_idx = vecs[i].idx;
      #1;
      chk($sformatf("v%0d_memwe", i), 64'(mem_we), 64'(vecs[i].we));
      chk($sformatf("v%0d_memaddr", i), 64'(mem_addr), 64'(vecs[i].addr));
      chk($sformatf("v%0d_memdata", i), 64'(mem_wdata), 64'(vecs[i].wdata));
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_rd", i), 64'(rd_data), 64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_cnt", i), 64'(res_count), 64'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_cpurst", i), 64'(cpu_rst), 64'(vecs[i].exp_done));
    end

    // DONE: outputs held, memory writes blocked, out-of-range index reads 0.
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_memwe", 64'(mem_we), 64'd0);
    rd_idx = 5'd9; #1;
    chk("done_rd9", 64'(rd_data), 64'd0);
    cpu_we = 1'b0;
    tick();
    chk("done_hold", 64'(done), 64'd1);

    // Restart from DONE with new args.
    args = {32'd5, 32'd9};
    rd_idx = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_rd2", 64'(rd_data), 64'd0);
    chk("restart_cnt", 64'(res_count), 64'd0);
    check_load(32'd9, 32'd5);

    // Reset two cycles into RUN after a capture.
    cpu_we = 1'b1; cpu_addr = 32'h0200_0014; cpu_wdata = 32'hDD; rd_idx = 5'd1;
    tick();
    chk("pre_rst_rd1", 64'(rd_data), 64'hDD);
    cpu_we = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_cpurst", 64'(cpu_rst), 64'd1);
    chk("abort_cnt", 64'(res_count), 64'd0);
    for (int i = 0; i < 32; i++) begin
      rd_idx = 5'(i); #1;
      chk($sformatf("abort_rd%0d", i), 64'(rd_data), 64'd0);
    end

    // Run with no done store.
    args = {32'd2, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("wd_running", 64'(cpu_rst), 64'd0);
`ifdef CPU_JOB_LOADER_TIMEOUT_EN
    for (int i = 0; i < 19; i++) tick();
    chk("wd_19_done", 64'(done), 64'd0);
    tick();
    chk("wd_20_done", 64'(done), 64'd1);
    chk("wd_20_to", 64'(timed_out), 64'd1);
    chk("wd_20_cpurst", 64'(cpu_rst), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_clear_to", 64'(timed_out), 64'd0);
`else
    for (int i = 0; i < 1000; i++) tick();
    chk("hang_busy", 64'(busy), 64'd1);
    chk("hang_done", 64'(done), 64'd0);
    chk("hang_to", 64'(timed_out), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_job_loader.md
Name: cpu_job_loader

Overview:
- Parametrised successor to the SP/EP write-point loader and path readback pair that sits between the host/top level, the riscv_cpu and data_mem.
- Accepts a job of NUM_ARGS argument words and holds the CPU in reset while it writes them into data memory.
- Releases the CPU, then snoops CPU stores to capture up to RES_DEPTH result words plus a completion flag.
- Presents the captured results on an indexed read port and owns the data-memory write mux.

Parameters:
- DATA_W, 32, data-memory word width
- ADDR_W, 32, data-memory address width
- NUM_ARGS, 2, argument words per job (1..16)
- ARG_BASE, 32'h0200_0000, byte address of argument 0; argument k is written at ARG_BASE+4k
- RES_BASE, 32'h0200_0010, byte address of result word 0
- RES_DEPTH, 9, result words captured (1..32)
- DONE_ADDR, 32'h0200_0040, CPU store here with nonzero data ends the job
- TIMEOUT_CYC, 65535, watchdog limit in RUN cycles (used only with the optional feature)

Ports:
- clk, in, 1, single clock
- reset, in, 1, synchronous active-high
- start, in, 1, one-cycle job request
- args, in, NUM_ARGS*DATA_W, argument words; word k is at [k*DATA_W +: DATA_W]; sampled on start
- cpu_we, in, 1, CPU store enable
- cpu_addr, in, ADDR_W, CPU data address
- cpu_wdata, in, DATA_W, CPU store data
- cpu_funct3, in, 3, CPU store size
- mem_we, out, 1, to data_mem
- mem_addr, out, ADDR_W, to data_mem
- mem_wdata, out, DATA_W, to data_mem
- mem_funct3, out, 3, to data_mem
- cpu_rst, out, 1, CPU reset, active-high
- busy, out, 1, job in progress
- done, out, 1, results valid, held until next start or reset
- res_count, out, 6, number of result slots written this job
- rd_idx, in, 5, result read index
- rd_data, out, DATA_W, combinational result word at rd_idx; 0 if rd_idx >= RES_DEPTH
- timed_out, out, 1, job ended by watchdog (tied 0 without the optional feature)

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Reset: state=IDLE, cpu_rst=1, busy=0, done=0, res_count=0, timed_out=0, result buffer cleared to 0, argument counter=0.
- Reset mid-job: the job is aborted and the block takes the reset values above on the next edge.
- IDLE:
  - cpu_rst=1.
  - On start: latch args, clear buffer and res_count, go to LOAD. busy=1 from the next cycle.
- LOAD:
  - One argument write per cycle: mem_we=1, mem_addr=ARG_BASE+4*k, mem_wdata=arg k, mem_funct3=3'b010.
  - The NUM_ARGS writes take exactly NUM_ARGS cycles. Leave for RUN after the write of arg NUM_ARGS-1.
  - cpu_rst=1 throughout. CPU inputs are ignored.
- RUN:
  - cpu_rst=0. mem_* pass cpu_* through combinationally.
  - A CPU store with RES_BASE <= cpu_addr < RES_BASE+4*RES_DEPTH captures cpu_wdata into slot (cpu_addr-RES_BASE)>>2 on the same edge.
  - Each write to a previously unwritten slot increments res_count. Rewriting a slot updates the data without incrementing.
  - Only word-aligned addresses are captured.
  - A CPU store to DONE_ADDR with nonzero data goes to DONE on the next edge and is also passed to memory.
  - If that same store also hits the result range, the capture still occurs.
- DONE:
  - cpu_rst=1, busy=0, done=1. The buffer is frozen.
  - start returns to LOAD directly and clears done on that edge.
- start in LOAD or RUN is ignored.
- Outside RUN, mem_we is driven only by LOAD. In IDLE and DONE: mem_we=0, with mem_addr/mem_wdata/mem_funct3 passing cpu_* (values are don't-care).
- Address arithmetic is modulo 2^ADDR_W.

Optional Feature:
- Macro: CPU_JOB_LOADER_TIMEOUT_EN.
- Defined:
  - A 32-bit RUN-cycle counter is cleared on entry to RUN.
  - When it reaches TIMEOUT_CYC without a done store, go to DONE with timed_out=1.
  - timed_out clears on start or reset.
- Undefined: no counter, timed_out tied 0, and RUN waits forever.

Decomposition:
- Package cpu_job_pkg holds:
  - the state encoding (IDLE, LOAD, RUN, DONE);
  - the constant FUNCT3_SW = 3'b010;
  - the default address constants.
- Sub-module job_result_buf: RES_DEPTH x DATA_W register file with a written-bit per slot, one write port, one combinational read port, and a synchronous clear.

Test Plan:
- Reset then start with args={EP=5'd17, SP=5'd3}:
  - mem writes 3 @0x02000000 then 17 @0x02000004 on two consecutive cycles;
  - cpu_rst falls on the third cycle.
- In RUN, CPU stores 0xA @RES_BASE+8 and 0xB @RES_BASE+8, then 1 @DONE_ADDR:
  - rd_idx=2 gives 0xB, res_count=1, done=1, cpu_rst=1.
- CPU store to RES_BASE+4*RES_DEPTH (one past the end):
  - not captured, res_count unchanged, store still reaches mem.
- Assert reset 2 cycles into RUN:
  - next cycle busy=0, done=0, cpu_rst=1, rd_data=0 for all indices.
- start during RUN is ignored. start in DONE:
  - done clears, LOAD re-writes the new args, buffer reads 0.
- With CPU_JOB_LOADER_TIMEOUT_EN and TIMEOUT_CYC=20, no done store:
  - after 20 RUN cycles done=1, timed_out=1;
  - without the macro, busy stays 1 after 1000 cycles.
